dual_port_ram_fifo: RTL and testbench

Synchronous valid/ready FIFO controller that sequences a single `DualPortRAM` instance as circular storage. It owns the write, fetch and pop pointers and drives the RAM read-port clock enable so the unregistered RAM output doubles as the FIFO output stage. It sits between any streaming producer and consumer in one clock domain, e.g. buffering sample streams between datapath stages.

---
 rtl/dual_port_ram_fifo_pkg.sv | 10 +
 rtl/dual_port_ram_fifo_ram.sv | 51 +++++
 rtl/dual_port_ram_fifo.sv | 109 ++++++++++
 tb/tb_dual_port_ram_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_fifo_pkg.sv
// Shared types for the dual-port-RAM backed FIFO controller.
package dual_port_ram_fifo_pkg;

  // Output stage: the unregistered RAM output either holds a valid head word or not.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage : dual_port_ram_fifo_pkg

// File: rtl/dual_port_ram_fifo_ram.sv
// Simple dual-port RAM with a registered, clock-enabled read address and an
// unregistered data output, so the address register doubles as the FIFO's
// output register.
module DualPortRAM #(
  parameter int    Width        = 32,
  parameter int    Depth        = 512,
  parameter string DeviceFamily = "Cyclone V",
  parameter string RamBlockType = "M10K"
) (
  input  logic                     ipClk,
  input  logic                     ipWrEnable,
  input  logic [$clog2(Depth)-1:0] ipWrAddress,
  input  logic [Width-1:0]         ipWrData,
  input  logic                     ipRdEnable,
  input  logic [$clog2(Depth)-1:0] ipRdAddress,
  output logic [Width-1:0]         opRdData
);

  localparam int AW = $clog2(Depth);

  // Cyclone IV E has no MLAB blocks, so an MLAB request there falls back to block RAM.
  localparam bit UseLutRam = (RamBlockType == "MLAB") && (DeviceFamily != "Cyclone IV E");

  logic [AW-1:0] rd_addr_q;

  // Read address only advances when a read is requested, so the output holds otherwise.
  always_ff @(posedge ipClk) begin
    if (ipRdEnable) rd_addr_q <= ipRdAddress;
  end

  if (UseLutRam) begin : g_lut_ram
    (* ramstyle = "MLAB, no_rw_check" *) logic [Width-1:0] mem [Depth];

    // Write port into LUT-based memory.
    always_ff @(posedge ipClk) begin
      if (ipWrEnable) mem[ipWrAddress] <= ipWrData;
    end

    assign opRdData = mem[rd_addr_q];
  end else begin : g_block_ram
    (* ramstyle = "no_rw_check" *) logic [Width-1:0] mem [Depth];

    // Write port into block memory.
    always_ff @(posedge ipClk) begin
      if (ipWrEnable) mem[ipWrAddress] <= ipWrData;
    end

    assign opRdData = mem[rd_addr_q];
  end

endmodule : DualPortRAM

// File: rtl/dual_port_ram_fifo.sv
// Valid/ready FIFO controller sequencing a single DualPortRAM as circular
// storage. The RAM output is the FIFO head; its location stays reserved
// until popped, so the writer is bounded by the pop pointer.
module dual_port_ram_fifo
  import dual_port_ram_fifo_pkg::*;
#(
  parameter int    Width        = 32,
  parameter int    Depth        = 512,
  parameter string DeviceFamily = "Cyclone V",
  parameter string RamBlockType = "M10K"
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic                   ipClear,
  input  logic [Width-1:0]       ipWrData,
  input  logic                   ipWrValid,
  output logic                   opWrReady,
  output logic [Width-1:0]       opRdData,
  output logic                   opRdValid,
  input  logic                   ipRdReady,
  output logic [$clog2(Depth):0] opUsedWords
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] DepthCount = (AW+1)'(Depth);
  localparam logic [AW:0] PtrOne     = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] fetch_ptr;
  logic [AW:0] pop_ptr;
  logic [AW:0] used_q;
  logic        wr_ready_q;
  out_state_e  out_state;

  logic        wr_fire;
  logic        pop_fire;
  logic        fetch;
  logic [AW:0] wr_ptr_next;
  logic [AW:0] pop_ptr_next;
  logic [AW:0] used_next;

  assign opRdValid   = (out_state == OUT_VALID);
  assign opWrReady   = wr_ready_q;
  assign opUsedWords = used_q;

  // Handshakes, fetch decision and next-state occupancy.
  always_comb begin
    wr_fire      = ipWrValid && wr_ready_q;
    pop_fire     = opRdValid && ipRdReady;
    fetch        = (fetch_ptr != wr_ptr) && (!opRdValid || ipRdReady);
    wr_ptr_next  = wr_fire  ? wr_ptr  + PtrOne : wr_ptr;
    pop_ptr_next = pop_fire ? pop_ptr + PtrOne : pop_ptr;
    used_next    = wr_ptr_next - pop_ptr_next;
  end

  // Pointers plus the registered ready and occupancy; a clear overrides all traffic.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      wr_ptr     <= '0;
      fetch_ptr  <= '0;
      pop_ptr    <= '0;
      used_q     <= '0;
      wr_ready_q <= 1'b0;
    end else if (ipClear) begin
      wr_ptr     <= '0;
      fetch_ptr  <= '0;
      pop_ptr    <= '0;
      used_q     <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_next;
      pop_ptr    <= pop_ptr_next;
      if (fetch) fetch_ptr <= fetch_ptr + PtrOne;
      used_q     <= used_next;
      wr_ready_q <= (used_next < DepthCount);
    end
  end

  // Output stage: a fetch always lands a valid head; a pop without a fetch empties it.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      out_state <= OUT_EMPTY;
    end else if (ipClear) begin
      out_state <= OUT_EMPTY;
    end else begin
      case (out_state)
        OUT_EMPTY: if (fetch) out_state <= OUT_VALID;
        OUT_VALID: if (pop_fire && !fetch) out_state <= OUT_EMPTY;
        default:   out_state <= OUT_EMPTY;
      endcase
    end
  end

  DualPortRAM #(
    .Width        (Width),
    .Depth        (Depth),
    .DeviceFamily (DeviceFamily),
    .RamBlockType (RamBlockType)
  ) u_ram (
    .ipClk       (ipClk),
    .ipWrEnable  (wr_fire && !ipClear),
    .ipWrAddress (wr_ptr[AW-1:0]),
    .ipWrData    (ipWrData),
    .ipRdEnable  (fetch && !ipClear),
    .ipRdAddress (fetch_ptr[AW-1:0]),
    .opRdData    (opRdData)
  );

endmodule : dual_port_ram_fifo

// File: tb/tb_dual_port_ram_fifo.sv
// Directed and scoreboard testbench for dual_port_ram_fifo (Depth 8, Width 16).
module tb_dual_port_ram_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [W-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [3:0]   used;

  int vectors;
  int miscompares;

  dual_port_ram_fifo #(
    .Width        (W),
    .Depth        (D),
    .DeviceFamily ("Cyclone V"),
    .RamBlockType ("M10K")
  ) dut (
    .ipClk       (clk),
    .ipReset     (rst_n),
    .ipClear     (clear),
    .ipWrData    (wr_data),
    .ipWrValid   (wr_valid),
    .opWrReady   (wr_ready),
    .opRdData    (rd_data),
    .opRdValid   (rd_valid),
    .ipRdReady   (rd_ready),
    .opUsedWords (used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || used !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: ready=%b valid=%b used=%0d, want 0/0/0", wr_ready, rd_valid, used);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || used !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: ready=%b valid=%b used=%0d, want 1/0/0", wr_ready, rd_valid, used);
    end
  endtask

  task automatic test_single_write();
    wr_data = 16'hA5A5; wr_valid = 1'b1; rd_ready = 1'b0;
    tick();
    wr_valid = 1'b0;
    vectors++;
    if (used !== 4'd1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_edge_k: used=%0d valid=%b, want 1/0", used, rd_valid);
    end
    tick();
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5 || used !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL single_edge_k1: valid=%b data=%h used=%0d, want 1/a5a5/1", rd_valid, rd_data, used);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
        miscompares++;
        $display("[TB] FAIL single_hold[%0d]: valid=%b data=%h, want 1/a5a5", i, rd_valid, rd_data);
      end
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++;
    if (used !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_pop: used=%0d valid=%b, want 0/0", used, rd_valid);
    end
  endtask

  task automatic test_full();
    rd_ready = 1'b0;
    for (int i = 1; i <= D; i++) begin
      vectors++;
      if (wr_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL full_fill_ready[%0d]: ready=%b, want 1", i, wr_ready);
      end
      wr_data = W'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    vectors++;
    if (used !== 4'd8 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_level: used=%0d ready=%b, want 8/0", used, wr_ready);
    end
    wr_data = 16'h0009; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    vectors++;
    if (used !== 4'd8 || rd_data !== 16'h0001) begin
      miscompares++;
      $display("[TB] FAIL full_overflow: used=%0d head=%h, want 8/0001", used, rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++;
    if (wr_ready !== 1'b1 || used !== 4'd7 || rd_valid !== 1'b1 || rd_data !== 16'h0002) begin
      miscompares++;
      $display("[TB] FAIL full_pop: ready=%b used=%0d valid=%b head=%h, want 1/7/1/0002", wr_ready, used, rd_valid, rd_data);
    end
    for (int i = 2; i <= D; i++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
        miscompares++;
        $display("[TB] FAIL full_drain[%0d]: valid=%b data=%h, want 1/%h", i, rd_valid, rd_data, W'(i));
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    vectors++;
    if (used !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_empty: used=%0d valid=%b, want 0/0 (9th word must not be stored)", used, rd_valid);
    end
  endtask

  task automatic test_stream();
    int sent;
    int recv;
    sent = 0; recv = 0;
    rd_ready = 1'b1;
    for (int c = 0; c < 106; c++) begin
      wr_valid = (sent < 100);
      wr_data  = 16'h0100 + W'(sent);
      if (wr_valid && wr_ready) sent++;
      tick();
      if (c >= 1 && c <= 100) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0100 + W'(c - 1)) begin
          miscompares++;
          $display("[TB] FAIL stream[%0d]: valid=%b data=%h, want 1/%h", c, rd_valid, rd_data, 16'h0100 + W'(c - 1));
        end
      end
      if (rd_valid) recv++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    vectors++;
    if (recv != 100 || sent != 100 || used !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL stream_count: sent=%0d recv=%0d used=%0d, want 100/100/0", sent, recv, used);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] prev_data;
    logic         prev_hold;
    logic         do_wr;
    logic         do_pop;
    for (int c = 0; c < 2000; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = W'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      do_wr     = wr_valid && wr_ready;
      do_pop    = rd_valid && rd_ready;
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      if (rd_valid) begin
        vectors++;
        if (q.size() == 0 || rd_data !== q[0]) begin
          miscompares++;
          $display("[TB] FAIL rand_head[%0d]: data=%h, want %h (model depth %0d)", c, rd_data, (q.size() == 0) ? 16'hxxxx : q[0], q.size());
        end
      end
      if (do_pop && q.size() != 0) void'(q.pop_front());
      if (do_wr) q.push_back(wr_data);
      tick();
      vectors++;
      if (used !== 4'(q.size()) || wr_ready !== (q.size() < D)) begin
        miscompares++;
        $display("[TB] FAIL rand_level[%0d]: used=%0d ready=%b, want %0d/%b", c, used, wr_ready, q.size(), q.size() < D);
      end
      if (prev_hold) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          miscompares++;
          $display("[TB] FAIL rand_stable[%0d]: valid=%b data=%h, want 1/%h", c, rd_valid, rd_data, prev_data);
        end
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      if (rd_valid) begin
        vectors++;
        if (rd_data !== q[0]) begin
          miscompares++;
          $display("[TB] FAIL rand_drain[%0d]: data=%h, want %h", c, rd_data, q[0]);
        end
        void'(q.pop_front());
      end
      tick();
    end
    rd_ready = 1'b0;
    vectors++;
    if (q.size() != 0 || used !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rand_final: model=%0d used=%0d valid=%b, want 0/0/0", q.size(), used, rd_valid);
    end
  endtask

  task automatic test_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'h0C00 + W'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    vectors++;
    if (used !== 4'd5 || rd_valid !== 1'b1 || rd_data !== 16'h0C00) begin
      miscompares++;
      $display("[TB] FAIL clear_fill: used=%0d valid=%b head=%h, want 5/1/0c00", used, rd_valid, rd_data);
    end
    clear = 1'b1; wr_data = 16'hDEAD; wr_valid = 1'b1; rd_ready = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    vectors++;
    if (used !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_empty: used=%0d valid=%b ready=%b, want 0/0/1", used, rd_valid, wr_ready);
    end
    tick();
    vectors++;
    if (used !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_lost: used=%0d valid=%b, want 0/0", used, rd_valid);
    end
    wr_data = 16'h1234; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    vectors++;
    if (used !== 4'd1 || rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL clear_reuse: used=%0d valid=%b data=%h, want 1/1/1234", used, rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'h0E00 + W'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (used !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_now: used=%0d valid=%b ready=%b, want 0/0/0", used, rd_valid, wr_ready);
    end
    tick(); tick();
    vectors++;
    if (wr_ready !== 1'b0 || used !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_hold: ready=%b used=%0d, want 0/0", wr_ready, used);
    end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #2;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_release: ready=%b, want 0 before first edge", wr_ready);
    end
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || used !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_after: ready=%b used=%0d valid=%b, want 1/0/0", wr_ready, used, rd_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_full();
    test_stream();
    test_random();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_dual_port_ram_fifo
